// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// Holds the sequencer state encoding and the port IDs used for round-robin history.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the F-stage fetch port and
// the M-stage load/store port. One transaction in flight; round-robin on contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_byteen,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                stall_i,
  output logic                stall_d,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arbState_e state;
  arbState_e stateNext;
  logic      lastGrant;
  logic      iElig;
  logic      dElig;
  logic      grantI;
  logic      grantD;
  logic      doneI;
  logic      doneD;

  // elig[0] = fetch, elig[1] = data; on a tie the port that did not win last time goes.
  function automatic logic pickPort(input logic [1:0] elig, input logic last);
    if (elig == 2'b11) begin
      return ~last;
    end
    return elig[1] ? PORT_D : PORT_I;
  endfunction

  assign stall_i = i_req & ~i_valid;
  assign stall_d = d_req & ~d_valid;

  always_comb begin
    iElig     = i_req & ~i_valid;
    dElig     = d_req & ~d_valid;
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    doneI     = 1'b0;
    doneD     = 1'b0;
    case (state)
      IDLE: begin
        if (iElig | dElig) begin
          if (pickPort({dElig, iElig}, lastGrant) == PORT_D) begin
            grantD    = 1'b1;
            stateNext = BUSY_D;
          end else begin
            grantI    = 1'b1;
            stateNext = BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          doneI     = 1'b1;
          stateNext = RESP;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          doneD     = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Registered memory request, completion pulses and returned read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lastGrant  <= PORT_I;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_byteen <= '0;
      mem_wdata  <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state   <= stateNext;
      i_valid <= doneI;
      d_valid <= doneD;
      if (grantI) begin
        mem_req    <= 1'b1;
        mem_addr   <= i_addr;
        mem_we     <= 1'b0;
        mem_byteen <= '1;
        mem_wdata  <= '0;
        lastGrant  <= PORT_I;
      end else if (grantD) begin
        mem_req    <= 1'b1;
        mem_addr   <= d_addr;
        mem_we     <= d_we;
        mem_byteen <= d_we ? d_byteen : '1;
        mem_wdata  <= d_wdata;
        lastGrant  <= PORT_D;
      end else if (doneI | doneD) begin
        mem_req <= 1'b0;
      end
      if (doneI) begin
        i_rdata <= mem_rdata;
      end
      if (doneD) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural variable-latency memory plus directed and
// randomized scenarios checked against a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_byteen;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              stall_i;
  logic              stall_d;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [BE_W-1:0]   mem_byteen;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  int nTests = 0;
  int nFail  = 0;

  // Memory model state
  int                memDelay = 0;
  bit                memStray = 1'b0;
  int                waitCnt;
  bit                unstable;
  logic [ADDR_W-1:0] mAddr;
  logic              mWe;
  logic [BE_W-1:0]   mBe;
  logic [DATA_W-1:0] mWd;
  logic [DATA_W-1:0] lastRd = '0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_i(stall_i), .stall_d(stall_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory answers after memDelay wait cycles; mem_ready decided at negedge for the next posedge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    waitCnt   = 0;
    unstable  = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (memStray) begin
        mem_ready = 1'b1;
      end else if (mem_req === 1'b1) begin
        if (waitCnt == 0) begin
          mAddr = mem_addr; mWe = mem_we; mBe = mem_byteen; mWd = mem_wdata;
        end else if ({mem_addr, mem_we, mem_byteen, mem_wdata} !== {mAddr, mWe, mBe, mWd}) begin
          unstable = 1'b1;
        end
        if (waitCnt >= memDelay) begin
          mem_ready = 1'b1;
          lastRd    = mem_rdata;
          waitCnt   = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_we = 1'b0;
    d_addr = '0; d_byteen = '0; d_wdata = '0; memStray = 1'b0; memDelay = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    nTests++;
    if ({mem_req, i_valid, d_valid, mem_we} !== 4'b0000) begin
      nFail++; $display("FAIL reset_ctrl: got req/iv/dv/we=%b expected 0000", {mem_req, i_valid, d_valid, mem_we});
    end
    nTests++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      nFail++; $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata);
    end
    nTests++;
    if (mem_addr !== '0 || mem_byteen !== '0 || mem_wdata !== '0) begin
      nFail++; $display("FAIL reset_mem: got addr=%h be=%h wd=%h expected 0", mem_addr, mem_byteen, mem_wdata);
    end
    nTests++;
    if ({stall_i, stall_d} !== 2'b00) begin
      nFail++; $display("FAIL reset_stall: got %b expected 00", {stall_i, stall_d});
    end
  endtask

  task automatic test_lone_fetch();
    memDelay = 0;
    i_req = 1'b1; i_addr = 32'h0000_3000;
    #1;
    nTests++;
    if (stall_i !== 1'b1) begin nFail++; $display("FAIL lone_stall_c0: got %b expected 1", stall_i); end
    @(negedge clk);
    nTests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_we !== 1'b0 || mem_byteen !== 4'hF) begin
      nFail++; $display("FAIL lone_mem_c1: got req=%b addr=%h we=%b be=%h expected 1 3000 0 f", mem_req, mem_addr, mem_we, mem_byteen);
    end
    nTests++;
    if (i_valid !== 1'b0 || stall_i !== 1'b1) begin
      nFail++; $display("FAIL lone_c1: got valid=%b stall=%b expected 0 1", i_valid, stall_i);
    end
    @(negedge clk);
    nTests++;
    if (i_valid !== 1'b1 || i_rdata !== lastRd || stall_i !== 1'b0 || mem_req !== 1'b0) begin
      nFail++; $display("FAIL lone_c2: got valid=%b rdata=%h stall=%b req=%b expected 1 %h 0 0", i_valid, i_rdata, stall_i, mem_req, lastRd);
    end
    i_req = 1'b0;
    @(negedge clk);
    nTests++;
    if (i_valid !== 1'b0) begin nFail++; $display("FAIL lone_c3: got valid=%b expected 0", i_valid); end
  endtask

  task automatic test_simultaneous();
    logic expPort;
    logic pendPort;
    logic prevReq;
    int   grants;
    applyReset();
    memDelay = $urandom_range(0, 2);
    i_req = 1'b1; i_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010; d_byteen = 4'h5; d_wdata = $urandom;
    expPort = 1'b1;
    pendPort = 1'b0;
    prevReq = 1'b0;
    grants = 0;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && prevReq !== 1'b1) begin
        nTests++;
        if (mem_addr !== (expPort ? d_addr : i_addr) || mem_we !== 1'b0 || mem_byteen !== 4'hF) begin
          nFail++; $display("FAIL rr_grant%0d: got addr=%h we=%b be=%h expected addr=%h we=0 be=f", grants, mem_addr, mem_we, mem_byteen, expPort ? d_addr : i_addr);
        end
        pendPort = expPort;
        expPort  = ~expPort;
        grants++;
      end
      if (i_valid === 1'b1 || d_valid === 1'b1) begin
        nTests++;
        if (i_valid !== ~pendPort || d_valid !== pendPort || (pendPort ? d_rdata : i_rdata) !== lastRd) begin
          nFail++; $display("FAIL rr_valid: got iv=%b dv=%b rdata=%h expected port=%0d rdata=%h", i_valid, d_valid, pendPort ? d_rdata : i_rdata, pendPort, lastRd);
        end
        memDelay = $urandom_range(0, 2);
      end
      prevReq = mem_req;
    end
    nTests++;
    if (grants != 6) begin nFail++; $display("FAIL rr_count: got %0d grants expected 6", grants); end
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_store_wait();
    memDelay = 3;
    unstable = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0004; d_byteen = 4'b0011; d_wdata = 32'h0000_BEEF;
    #1;
    nTests++;
    if (stall_d !== 1'b1) begin nFail++; $display("FAIL store_stall_c0: got %b expected 1", stall_d); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      nTests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 1'b1 || mem_byteen !== 4'b0011 ||
          mem_wdata !== 32'h0000_BEEF || d_valid !== 1'b0 || stall_d !== 1'b1) begin
        nFail++; $display("FAIL store_hold_c%0d: got req=%b addr=%h we=%b be=%b wd=%h dv=%b stall=%b expected 1 4 1 0011 beef 0 1", c, mem_req, mem_addr, mem_we, mem_byteen, mem_wdata, d_valid, stall_d);
      end
    end
    @(negedge clk);
    nTests++;
    if (d_valid !== 1'b1 || mem_req !== 1'b0 || stall_d !== 1'b0 || d_rdata !== lastRd) begin
      nFail++; $display("FAIL store_done: got dv=%b req=%b stall=%b rdata=%h expected 1 0 0 %h", d_valid, mem_req, stall_d, d_rdata, lastRd);
    end
    nTests++;
    if (unstable !== 1'b0) begin nFail++; $display("FAIL store_stable: got unstable=%b expected 0", unstable); end
    d_req = 1'b0;
    @(negedge clk);
    nTests++;
    if (d_valid !== 1'b0) begin nFail++; $display("FAIL store_pulse: got dv=%b expected 0", d_valid); end
  endtask

  task automatic test_back_to_back();
    int   rise[$];
    int   nValid;
    int   expValid;
    logic prevReq;
    memDelay = 0;
    nValid = 0;
    prevReq = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_4000;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && prevReq !== 1'b1) rise.push_back(c);
      if (i_valid === 1'b1) nValid++;
      prevReq = mem_req;
    end
    nTests++;
    if (rise.size() < 4 || rise[0] != 1) begin
      nFail++; $display("FAIL b2b_rises: got %0d rises first=%0d expected >=4 first=1", rise.size(), rise.size() > 0 ? rise[0] : -1);
    end
    for (int k = 1; k < rise.size(); k++) begin
      nTests++;
      if (rise[k] - rise[k-1] != 3) begin
        nFail++; $display("FAIL b2b_gap%0d: got %0d expected 3", k, rise[k] - rise[k-1]);
      end
    end
    expValid = 0;
    foreach (rise[k]) if (rise[k] + 1 <= 13) expValid++;
    nTests++;
    if (nValid != expValid) begin nFail++; $display("FAIL b2b_valids: got %0d expected %0d", nValid, expValid); end
    i_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit bad;
    memDelay = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
    @(negedge clk);
    nTests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      nFail++; $display("FAIL rstmid_busy: got req=%b addr=%h we=%b expected 1 80 0", mem_req, mem_addr, mem_we);
    end
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    nTests++;
    if ({mem_req, i_valid, d_valid, mem_we, stall_i, stall_d} !== 6'b0 || i_rdata !== '0 || d_rdata !== '0 ||
        mem_addr !== '0 || mem_byteen !== '0 || mem_wdata !== '0) begin
      nFail++; $display("FAIL rstmid_outputs: got req=%b iv=%b dv=%b addr=%h be=%h ir=%h dr=%h expected all 0", mem_req, i_valid, d_valid, mem_addr, mem_byteen, i_rdata, d_rdata);
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (d_valid !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
    end
    nTests++;
    if (bad) begin nFail++; $display("FAIL rstmid_quiet: got activity after reset expected none"); end
    memDelay = 0;
    i_req = 1'b1; i_addr = 32'h0000_5000;
    @(negedge clk);
    nTests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h5000) begin
      nFail++; $display("FAIL rstmid_idle: got req=%b addr=%h expected 1 5000", mem_req, mem_addr);
    end
    @(negedge clk);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stray_ready();
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] dr;
    bit                bad;
    ir = i_rdata;
    dr = d_rdata;
    bad = 1'b0;
    memStray = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (i_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
    end
    memStray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (i_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
    end
    nTests++;
    if (bad) begin nFail++; $display("FAIL stray_pulse: got valid or req during stray ready expected none"); end
    nTests++;
    if (i_rdata !== ir || d_rdata !== dr) begin
      nFail++; $display("FAIL stray_rdata: got i=%h d=%h expected i=%h d=%h", i_rdata, d_rdata, ir, dr);
    end
    memDelay = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
    @(negedge clk);
    nTests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin
      nFail++; $display("FAIL stray_idle: got req=%b addr=%h expected 1 700", mem_req, mem_addr);
    end
    @(negedge clk);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic              lg;
    int                mode;
    int                order[$];
    int                dl[2];
    int                expRise;
    int                expValid;
    int                k;
    int                t;
    logic              dw;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] da;
    logic              prevReq;
    logic              vPort;
    applyReset();
    lg = 1'b0;
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(1, 3);
      ia = $urandom & 32'hFFFF_FFFC;
      da = $urandom & 32'hFFFF_FFFC;
      dw = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
      dl[0] = $urandom_range(0, 4);
      dl[1] = $urandom_range(0, 4);
      order.delete();
      if (mode == 3) begin
        order.push_back(lg ? 0 : 1);
        order.push_back(lg ? 1 : 0);
      end else begin
        order.push_back(mode == 1 ? 0 : 1);
      end
      memDelay = dl[0];
      i_req = mode[0]; i_addr = ia;
      d_req = mode[1]; d_we = dw; d_addr = da; d_byteen = be; d_wdata = wd;
      k = 0;
      expRise = 1;
      expValid = dl[0] + 2;
      prevReq = 1'b0;
      t = 0;
      while (k < order.size() && t < 40) begin
        @(negedge clk);
        t++;
        if (mem_req === 1'b1 && prevReq !== 1'b1) begin
          nTests++;
          if (t != expRise || mem_addr !== (order[k] == 1 ? da : ia) || mem_we !== (order[k] == 1 ? dw : 1'b0) ||
              mem_byteen !== ((order[k] == 1 && dw) ? be : 4'hF) || (order[k] == 1 && dw && mem_wdata !== wd)) begin
            nFail++; $display("FAIL rnd%0d_grant%0d: got t=%0d addr=%h we=%b be=%h wd=%h expected t=%0d port=%0d", r, k, t, mem_addr, mem_we, mem_byteen, mem_wdata, expRise, order[k]);
          end
        end
        if (i_valid === 1'b1 || d_valid === 1'b1) begin
          vPort = d_valid;
          nTests++;
          if ((i_valid & d_valid) || int'(vPort) != order[k] || t != expValid ||
              (vPort ? d_rdata : i_rdata) !== lastRd || (vPort ? stall_d : stall_i) !== 1'b0) begin
            nFail++; $display("FAIL rnd%0d_valid%0d: got iv=%b dv=%b t=%0d rdata=%h expected port=%0d t=%0d rdata=%h", r, k, i_valid, d_valid, t, vPort ? d_rdata : i_rdata, order[k], expValid, lastRd);
          end
          if (vPort) d_req = 1'b0;
          else i_req = 1'b0;
          memDelay = dl[1];
          expRise  = expValid + 2;
          expValid = expValid + 1 + dl[1] + 2;
          k++;
        end
        prevReq = mem_req;
      end
      nTests++;
      if (k != order.size()) begin
        nFail++; $display("FAIL rnd%0d_timeout: got %0d completions expected %0d", r, k, order.size());
      end
      lg = (order[order.size()-1] == 1);
      i_req = 1'b0; d_req = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_we = 1'b0;
    d_addr = '0; d_byteen = '0; d_wdata = '0;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_store_wait();
    test_back_to_back();
    test_reset_mid();
    test_stray_ready();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within time limit expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the instruction-fetch port (F stage) and the load/store port (M stage) of the 5-stage MIPS pipeline. It arbitrates between the two, sequences one memory transaction at a time, and returns registered read data. It also produces per-port stall requests that the hazard unit ORs into its global stall.

## Interface
- ADDR_W, 32, address width (byte address, word aligned by requesters)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held high until i_valid seen
- i_addr  in  ADDR_W  fetch address; stable while i_req high
- i_rdata  out  DATA_W  fetched word; reset 0
- i_valid  out  1  one-cycle completion pulse for fetch; reset 0
- d_req  in  1  load/store request; held high until d_valid seen
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_byteen  in  DATA_W/8  store byte enables (ignored for loads)
- d_wdata  in  DATA_W  store data, already lane-aligned
- d_rdata  out  DATA_W  load word (raw; sign/zero fix is downstream); reset 0
- d_valid  out  1  one-cycle completion pulse for data; reset 0
- stall_i  out  1  combinational: i_req & ~i_valid
- stall_d  out  1  combinational: d_req & ~d_valid
- mem_req  out  1  registered memory request; reset 0
- mem_addr, mem_we, mem_byteen, mem_wdata  out  ADDR_W/1/DATA_W/8/DATA_W  registered, stable while mem_req high; reset 0
- mem_ready  in  1  memory completes current request this cycle
- mem_rdata  in  DATA_W  valid when mem_ready high

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset -> IDLE, last_grant = I.
- IDLE: eligible port = req high and its valid not high this cycle. One eligible -> grant it. Both eligible -> grant the port not equal to last_grant (round-robin). Grant latches address/controls into mem_* regs, sets mem_req=1, updates last_grant, moves to BUSY_I/BUSY_D. None eligible -> stay.
- For fetch grants, mem_we=0 and mem_byteen=all ones; for loads, mem_byteen=all ones; for stores, mem_byteen=d_byteen.
- BUSY_x: hold mem_* constant. On mem_ready: capture mem_rdata into x_rdata, drop mem_req, pulse x_valid next cycle, go to RESP.
- RESP: x_valid=1 for exactly this cycle; return to IDLE. Requests are not arbitrated in RESP.
- Store completion also pulses d_valid; d_rdata is then updated with mem_rdata (don't-care to consumer).
- i_rdata/d_rdata hold their last value until overwritten by the next completion on that port.
- mem_ready outside BUSY_x is ignored.

## Timing
- Cycle 0 req sampled in IDLE -> cycle 1 mem_req=1 -> mem_ready in cycle k≥1 -> cycle k+1 x_valid=1 -> cycle k+2 IDLE, arbitrating again.
- Minimum latency req->valid: 2 cycles. Max throughput with zero-wait memory: one access per 3 cycles.
- Stall deasserts in the same cycle valid asserts, so the pipeline advances on that edge.
- Requester may drop req or present a new request in the cycle after valid. A req held through the valid cycle is seen as a new request in IDLE.
- Reset mid-transaction: next cycle state IDLE, mem_req=0, pending response dropped, no valid pulse. The memory must tolerate an abandoned request.
- Both req rising together out of reset: data wins, because last_grant resets to I.

## Structure
- Shared package: state enum (IDLE, BUSY_I, BUSY_D, RESP) and port-ID constants PORT_I/PORT_D for last_grant.
- Single flat module; no sub-module. The round-robin pick is a 2-input function inside the block.

## Test plan
- Lone fetch, mem_ready tied 1: i_req@0 with i_addr=0x3000 -> mem_req@1 addr 0x3000, i_valid@2 with i_rdata=mem_rdata, stall_i high cycles 0–1.
- Simultaneous i_req/d_req after reset, d_we=0, addr 0x0010: load granted first. Fetch granted next IDLE. Grants then alternate while both stay high.
- Store d_addr=0x0004, d_byteen=4'b0011, d_wdata=0x0000BEEF, mem_ready delayed 3 cycles: mem_* stable for 4 cycles; d_valid 1 cycle after mem_ready; stall_d high until then.
- Back-to-back fetches with i_req held high: second mem_req appears exactly 3 cycles after the first with zero-wait memory. No duplicate grant in RESP.
- Reset asserted in BUSY_D with mem_ready low: next cycle mem_req=0, state IDLE, d_valid never pulses, all outputs 0.
- Stray mem_ready in IDLE: no valid pulse, no state change.
